// File: rtl/wave_pkg.sv
// Shared types and default widths for the waveform
// generator and measurement blocks.
package wave_pkg;

  localparam int WAVE_VAL_BITS = 7;
  localparam int WAVE_PER_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    MEASURE
  } wave_state_t;

endpackage

// File: rtl/wave_meter_wrap_detect.sv
// Two-deep sample pipeline and downward-wrap detector
// with a minimum drop threshold.
module wrap_detect
  import wave_pkg::*;
#(
  parameter int VAL_BITS = WAVE_VAL_BITS,
  parameter int DROP_MIN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [VAL_BITS-1:0] val,
  output logic [VAL_BITS-1:0] val_q,
  output logic                wrap
);

  localparam logic [VAL_BITS-1:0] DROP = VAL_BITS'(DROP_MIN);

  logic [VAL_BITS-1:0] val_p;
  logic [VAL_BITS-1:0] drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      val_p <= '0;
    end else begin
      val_q <= val;
      val_p <= val_q;
    end
  end

  // Only meaningful when val_q < val_p, so no underflow.
  assign drop = val_p - val_q;
  assign wrap = (val_q < val_p) && (drop >= DROP);

endmodule

// File: rtl/wave_meter.sv
// Period and per-period min/max meter for a sampled
// periodic waveform; a period ends on a downward wrap.
module wave_meter
  import wave_pkg::*;
#(
  parameter int VAL_BITS = WAVE_VAL_BITS,
  parameter int PER_BITS = WAVE_PER_BITS,
  parameter int DROP_MIN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [VAL_BITS-1:0] val,
  output logic [PER_BITS-1:0] period,
  output logic [VAL_BITS-1:0] vmin,
  output logic [VAL_BITS-1:0] vmax,
  output logic                valid,
  output logic                locked,
  output logic                overflow
);

  localparam logic [PER_BITS-1:0] CNT_MAX = '1;
  localparam logic [PER_BITS-1:0] CNT_ONE = PER_BITS'(1);

  wave_state_t         state;
  logic [PER_BITS-1:0] cnt;
  logic [VAL_BITS-1:0] run_min;
  logic [VAL_BITS-1:0] run_max;
  logic [VAL_BITS-1:0] val_q;
  logic                wrap;

  wrap_detect #(
    .VAL_BITS (VAL_BITS),
    .DROP_MIN (DROP_MIN)
  ) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .val   (val),
    .val_q (val_q),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      run_min  <= '0;
      run_max  <= '0;
      period   <= '0;
      vmin     <= '0;
      vmax     <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        cnt    <= '0;
        locked <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt   <= '0;
            state <= SYNC;
          end
          SYNC: begin
            if (wrap) begin
              state   <= MEASURE;
              cnt     <= CNT_ONE;
              run_min <= val_q;
              run_max <= val_q;
            end
          end
          MEASURE: begin
            if (wrap) begin
              // Wrap sample opens the new period.
              period   <= cnt;
              vmin     <= run_min;
              vmax     <= run_max;
              valid    <= 1'b1;
              locked   <= 1'b1;
              overflow <= 1'b0;
              cnt      <= CNT_ONE;
              run_min  <= val_q;
              run_max  <= val_q;
            end else if (cnt == CNT_MAX) begin
              overflow <= 1'b1;
              locked   <= 1'b0;
              cnt      <= '0;
              state    <= SYNC;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (val_q < run_min) run_min <= val_q;
              if (val_q > run_max) run_max <= val_q;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter with a result scoreboard
// checked whenever a DUT raises valid.
module tb_wave_meter;

  typedef struct {
    logic [31:0] p;
    logic [31:0] mn;
    logic [31:0] mx;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       en3 = 1'b0;
  logic [2:0] val = '0;

  logic [7:0] period, period3;
  logic [2:0] vmin, vmax, vmin3, vmax3;
  logic       valid, locked, overflow;
  logic       valid3, locked3, overflow3;

  int   checks = 0;
  int   passed = 0;
  res_t q1[$];
  res_t q3[$];

  wave_meter #(.VAL_BITS(3), .PER_BITS(8), .DROP_MIN(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .val      (val),
    .period   (period),
    .vmin     (vmin),
    .vmax     (vmax),
    .valid    (valid),
    .locked   (locked),
    .overflow (overflow)
  );

  wave_meter #(.VAL_BITS(3), .PER_BITS(8), .DROP_MIN(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en3),
    .val      (val),
    .period   (period3),
    .vmin     (vmin3),
    .vmax     (vmax3),
    .valid    (valid3),
    .locked   (locked3),
    .overflow (overflow3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic step(input logic [2:0] v);
    val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int p, input int mn, input int mx);
    res_t r;
    r.p = p; r.mn = mn; r.mx = mx;
    q1.push_back(r);
  endtask

  task automatic push3(input int p, input int mn, input int mx);
    res_t r;
    r.p = p; r.mn = mn; r.mx = mx;
    q3.push_back(r);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (q1.size() == 0) chk("spurious_valid", 32'(valid), 0);
      else begin
        res_t r;
        r = q1.pop_front();
        chk("period", 32'(period), r.p);
        chk("vmin", 32'(vmin), r.mn);
        chk("vmax", 32'(vmax), r.mx);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid3) begin
      if (q3.size() == 0) chk("spurious_valid3", 32'(valid3), 0);
      else begin
        res_t r;
        r = q3.pop_front();
        chk("period3", 32'(period3), r.p);
        chk("vmin3", 32'(vmin3), r.mn);
        chk("vmax3", 32'(vmax3), r.mx);
      end
    end
  end

  initial begin
    int n;
    #12;
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    en = 1'b1;
    step(0);
    step(0);

    // Ramp lock: four wraps, three reports
    for (int k = 0; k < 3; k++) push1(16, 0, 7);
    for (int r = 0; r < 4; r++)
      for (int v = 0; v < 8; v++) begin
        step(3'(v));
        step(3'(v));
      end
    step(0);
    chk("ramp_latency_early", 32'(valid), 0);
    step(0);
    chk("ramp_latency_valid", 32'(valid), 1);
    chk("ramp_locked", 32'(locked), 1);

    // Back-to-back wraps
    push1(3, 0, 7);
    for (int v = 6; v >= 1; v--) push1(1, v, v);
    for (int v = 7; v >= 0; v--) step(3'(v));

    // Timeout while holding a flat value
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      step(4);
      n = i;
      if (overflow) break;
    end
    chk("to_cycles", n, 256);
    chk("to_locked", 32'(locked), 0);
    chk("to_period_hold", 32'(period), 1);
    step(0);
    chk("to_ovf_sticky", 32'(overflow), 1);
    push1(4, 0, 4);
    step(4); step(4); step(4);
    step(0);
    step(0);
    chk("to_ovf_clear", 32'(overflow), 0);
    chk("to_relock", 32'(locked), 1);

    // Enable drop spanning a wrap
    step(4); step(4);
    en = 1'b0;
    step(4);
    step(0);
    step(0);
    chk("en_valid", 32'(valid), 0);
    chk("en_locked", 32'(locked), 0);
    chk("en_period_hold", 32'(period), 4);
    en = 1'b1;
    step(0);
    step(4); step(4); step(4);
    step(0);
    push1(6, 0, 4);
    for (int i = 0; i < 5; i++) step(4);
    step(0);
    step(0);
    chk("en_relock", 32'(locked), 1);

    // Partial waveform on both thresholds
    en = 1'b0;
    step(0);
    en = 1'b1;
    en3 = 1'b1;
    step(0);
    for (int k = 0; k < 7; k++)
      if (k % 2 == 0) push1(2, 3, 6);
      else push1(3, 1, 5);
    for (int k = 0; k < 3; k++) push3(5, 1, 6);
    for (int r = 0; r < 4; r++) begin
      step(2); step(5); step(3); step(6); step(1);
    end
    step(1);
    step(1);
    chk("part_locked3", 32'(locked3), 1);
    en3 = 1'b0;

    // Asynchronous reset mid-period
    step(5);
    step(6);
    rst_n = 1'b0;
    #1;
    chk("mrst_period", 32'(period), 0);
    chk("mrst_vmin", 32'(vmin), 0);
    chk("mrst_vmax", 32'(vmax), 0);
    chk("mrst_locked", 32'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    step(0);
    step(3);
    step(3);
    push1(3, 0, 3);
    step(0);
    step(0);
    step(0);
    chk("mrst_relock", 32'(locked), 1);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
